// File: rtl/menu_button_ctrl.sv
// menu_button_ctrl
// Mouse-driven menu buttons (Start, Connect) and the link handshake that the
// Connect button starts.
//   clk, rst                 : clock, synchronous active-high reset
//   mouse_x, mouse_y         : pointer position in screen pixels
//   MOUSE_LEFT               : left button level, 1 = pressed
//   link_ack, link_lost      : one-cycle pulses from the link block
//   mouse_on_start_button    : pointer is over Start (registered)
//   mouse_on_connect_button  : pointer is over Connect (registered)
//   start_pulse              : one-cycle pulse when Start is clicked
//   connect_req              : level, a connection request is outstanding
//   connected                : level, the link is up
module menu_button_ctrl #(
  parameter logic [9:0]  START_X0 = 10'd220,
  parameter logic [9:0]  START_X1 = 10'd419,
  parameter logic [9:0]  START_Y0 = 10'd200,
  parameter logic [9:0]  START_Y1 = 10'd299,
  parameter logic [9:0]  CONN_X0  = 10'd220,
  parameter logic [9:0]  CONN_X1  = 10'd419,
  parameter logic [9:0]  CONN_Y0  = 10'd320,
  parameter logic [9:0]  CONN_Y1  = 10'd419,
  parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       MOUSE_LEFT,
  input  logic       link_ack,
  input  logic       link_lost,
  output logic       mouse_on_start_button,
  output logic       mouse_on_connect_button,
  output logic       start_pulse,
  output logic       connect_req,
  output logic       connected
);

  typedef enum logic [1:0] {C_IDLE, C_PRESS_START, C_PRESS_CONN, C_PRESS_NONE} click_e;
  typedef enum logic [1:0] {L_DISC, L_REQ, L_CONN} link_e;

  click_e      click_q, click_d;
  link_e       link_q, link_d;
  logic [23:0] cnt_q, cnt_d;
  logic        hov_s_q, hov_s_d, hov_c_q, hov_c_d;
  logic        left_q;
  logic        start_pulse_q, start_pulse_d;
  logic        conn_click_q, conn_click_d;
  logic        connect_req_q, connected_q;
  logic        press, release_ev;

  // Inclusive rectangle tests on the live pointer position
  assign hov_s_d = (mouse_x >= START_X0) && (mouse_x <= START_X1) &&
                   (mouse_y >= START_Y0) && (mouse_y <= START_Y1);
  assign hov_c_d = (mouse_x >= CONN_X0) && (mouse_x <= CONN_X1) &&
                   (mouse_y >= CONN_Y0) && (mouse_y <= CONN_Y1);

  assign press      =  MOUSE_LEFT && !left_q;
  assign release_ev = !MOUSE_LEFT &&  left_q;

  // Click FSM: a click counts only if press and release both happen over the
  // same button, judged by the registered hover flags.
  always_comb begin
    click_d       = click_q;
    start_pulse_d = 1'b0;
    conn_click_d  = 1'b0;
    case (click_q)
      C_IDLE: if (press) begin
        if (hov_s_q)      click_d = C_PRESS_START;
        else if (hov_c_q) click_d = C_PRESS_CONN;
        else              click_d = C_PRESS_NONE;
      end
      C_PRESS_START: if (release_ev) begin
        click_d       = C_IDLE;
        start_pulse_d = hov_s_q;
      end
      C_PRESS_CONN: if (release_ev) begin
        click_d      = C_IDLE;
        conn_click_d = hov_c_q;
      end
      C_PRESS_NONE: if (release_ev) click_d = C_IDLE;
      default: click_d = C_IDLE;
    endcase
  end

  // Link FSM: lost beats ack beats timeout while a request is pending.
  always_comb begin
    link_d = link_q;
    cnt_d  = cnt_q;
    case (link_q)
      L_DISC: if (conn_click_q) begin
        link_d = L_REQ;
        cnt_d  = '0;
      end
      L_REQ: begin
        if (link_lost)                       link_d = L_DISC;
        else if (link_ack)                   link_d = L_CONN;
        else if (cnt_q == TIMEOUT - 24'd1)   link_d = L_DISC;
        else                                 cnt_d  = cnt_q + 24'd1;
      end
      L_CONN: if (link_lost) link_d = L_DISC;
      default: link_d = L_DISC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      click_q       <= C_IDLE;
      link_q        <= L_DISC;
      cnt_q         <= '0;
      hov_s_q       <= 1'b0;
      hov_c_q       <= 1'b0;
      left_q        <= 1'b0;
      start_pulse_q <= 1'b0;
      conn_click_q  <= 1'b0;
      connect_req_q <= 1'b0;
      connected_q   <= 1'b0;
    end else begin
      click_q       <= click_d;
      link_q        <= link_d;
      cnt_q         <= cnt_d;
      hov_s_q       <= hov_s_d;
      hov_c_q       <= hov_c_d;
      left_q        <= MOUSE_LEFT;
      start_pulse_q <= start_pulse_d;
      conn_click_q  <= conn_click_d;
      // Decoded from next state so the levels line up with link_q
      connect_req_q <= (link_d == L_REQ);
      connected_q   <= (link_d == L_CONN);
    end
  end

  assign mouse_on_start_button   = hov_s_q;
  assign mouse_on_connect_button = hov_c_q;
  assign start_pulse             = start_pulse_q;
  assign connect_req             = connect_req_q;
  assign connected               = connected_q;

endmodule

// File: tb/tb_menu_button_ctrl.sv
module tb_menu_button_ctrl;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] mouse_x = '0, mouse_y = '0;
  logic       MOUSE_LEFT = 1'b0, link_ack = 1'b0, link_lost = 1'b0;
  logic       hs, hc, sp, creq, conn;

  int tests = 0, fails = 0;

  menu_button_ctrl #(.TIMEOUT(24'(TO))) dut (
    .clk(clk), .rst(rst), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .MOUSE_LEFT(MOUSE_LEFT), .link_ack(link_ack), .link_lost(link_lost),
    .mouse_on_start_button(hs), .mouse_on_connect_button(hc),
    .start_pulse(sp), .connect_req(creq), .connected(conn)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // e_* are the output values expected after the most recent edge.
  bit e_hs, e_hc, e_sp, e_creq, e_conn, m_valid;
  bit m_left, m_click_pending;
  int m_grab;   // where the current press landed: 0 none, 1 start, 2 connect, 3 elsewhere
  int m_age;    // cycles a request has been waiting

  function automatic bit in_box(int x, int y, int x0, int x1, int y0, int y1);
    return x >= x0 && x <= x1 && y >= y0 && y <= y1;
  endfunction

  always @(posedge clk) begin
    bit pressed, released, new_sp, new_click;
    if (rst) begin
      {e_hs, e_hc, e_sp, e_creq, e_conn} = '0;
      m_left = 0; m_click_pending = 0; m_grab = 0; m_age = 0; m_valid = 1;
    end else begin
      pressed  = MOUSE_LEFT && !m_left;
      released = !MOUSE_LEFT && m_left;
      new_sp = 0; new_click = 0;
      if (m_grab == 0 && pressed)
        m_grab = e_hs ? 1 : (e_hc ? 2 : 3);
      else if (m_grab != 0 && released) begin
        new_sp    = (m_grab == 1) && e_hs;
        new_click = (m_grab == 2) && e_hc;
        m_grab = 0;
      end
      if (e_creq) begin
        if (link_lost)              e_creq = 0;
        else if (link_ack)          begin e_creq = 0; e_conn = 1; end
        else if (m_age == TO - 1)   e_creq = 0;
        else                        m_age++;
      end else if (e_conn) begin
        if (link_lost) e_conn = 0;
      end else if (m_click_pending) begin
        e_creq = 1; m_age = 0;
      end
      m_click_pending = new_click;
      e_sp = new_sp;
      e_hs = in_box(mouse_x, mouse_y, 220, 419, 200, 299);
      e_hc = in_box(mouse_x, mouse_y, 220, 419, 320, 419);
      m_left = MOUSE_LEFT;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if ({hs, hc, sp, creq, conn} !== {e_hs, e_hc, e_sp, e_creq, e_conn}) begin
        fails++;
        $display("FAIL cycle_compare t=%0t got hs/hc/sp/req/conn=%b%b%b%b%b want %b%b%b%b%b",
                 $time, hs, hc, sp, creq, conn, e_hs, e_hc, e_sp, e_creq, e_conn);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic move(int x, int y);
    mouse_x = 10'(x); mouse_y = 10'(y);
  endtask

  // press, hold, release at the current position; the click is sampled at the
  // release edge
  task automatic click(int hold);
    MOUSE_LEFT = 1; tick(hold); MOUSE_LEFT = 0; tick();
  endtask

  task automatic count_sp(int n, output int c);
    c = 0;
    repeat (n) begin c += sp; tick(); end
  endtask

  task automatic wait_req(string name);
    int k = 0;
    while (!creq && k < 10) begin tick(); k++; end
    chk(name, int'(creq), 1);
  endtask

  initial begin
    int c;
    tick(2);
    rst = 0;
    chk("reset_outputs", int'({hs, hc, sp, creq, conn}), 0);

    // hover boundaries
    move(220, 200); tick(); chk("hover_start_corner", hs, 1);
    move(219, 200); tick(); chk("hover_start_left_out", hs, 0);
    move(419, 419); tick(); chk("hover_conn_corner", hc, 1);
    move(420, 419); tick(); chk("hover_conn_right_out", hc, 0);

    // clean start click
    move(300, 250); tick();
    click(5);
    count_sp(6, c);
    chk("start_pulse_count", c, 1);
    chk("start_no_connect", conn, 0);

    // drag out cancels
    MOUSE_LEFT = 1; tick(); move(100, 100); tick(2); MOUSE_LEFT = 0;
    count_sp(4, c); chk("drag_out_no_pulse", c, 0);
    // drag in never clicks
    MOUSE_LEFT = 1; tick(); move(300, 250); tick(2); MOUSE_LEFT = 0;
    count_sp(4, c); chk("drag_in_no_pulse", c, 0);

    // connect handshake
    move(300, 350); tick();
    click(2);
    tick(); chk("connect_req_up", creq, 1);
    tick(3); link_ack = 1; tick(); link_ack = 0;
    chk("connected_after_ack", conn, 1);
    chk("req_drop_after_ack", creq, 0);
    click(2); tick(3);
    chk("second_click_conn", conn, 1);
    chk("second_click_req", creq, 0);
    link_lost = 1; tick(); link_lost = 0;
    chk("lost_disconnects", conn, 0);

    // timeout
    click(2);
    c = 0;
    repeat (30) begin c += creq; tick(); end
    chk("timeout_req_cycles", c, TO);
    chk("timeout_not_connected", conn, 0);

    // lost beats ack
    click(2); wait_req("req_before_collision");
    link_ack = 1; link_lost = 1; tick(); link_ack = 0; link_lost = 0;
    chk("collision_req", creq, 0);
    chk("collision_conn", conn, 0);

    // reset during a pending request, button held across reset
    click(2); wait_req("req_before_reset");
    MOUSE_LEFT = 1; tick();
    rst = 1; tick(); rst = 0;
    chk("midreset_outputs", int'({hs, hc, sp, creq, conn}), 0);
    tick(3); MOUSE_LEFT = 0; tick();
    c = 0;
    repeat (20) begin c += creq; tick(); end
    chk("no_req_after_reset", c, 0);
    click(2); wait_req("req_after_new_click");
    link_lost = 1; tick(); link_lost = 0;

    // randomized traffic, checked cycle-by-cycle by the model
    repeat (3000) begin
      if ($urandom_range(3) == 0) move($urandom_range(200, 440), $urandom_range(180, 440));
      if ($urandom_range(5) == 0) MOUSE_LEFT = ~MOUSE_LEFT;
      link_ack  = ($urandom_range(9) == 0);
      link_lost = ($urandom_range(29) == 0);
      rst       = ($urandom_range(499) == 0);
      tick();
    end
    rst = 0; link_ack = 0; link_lost = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/menu_button_ctrl.md
MENU_BUTTON_CTRL -- requirements
Module: menu_button_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be as follows; all bounds are inclusive:
- START_X0 = 220, START_X1 = 419, START_Y0 = 200, START_Y1 = 299: Start button region, screen pixels.
- CONN_X0 = 220, CONN_X1 = 419, CONN_Y0 = 320, CONN_Y1 = 419: Connect button region.
- TIMEOUT = 10_000_000: connect-request timeout in clk cycles, held in a 24-bit counter.
REQ-003 Ports SHALL be as follows:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mouse_x  in  10  pointer column, 0..639
- mouse_y  in  10  pointer row, 0..479
- MOUSE_LEFT  in  1  left button level, 1 = pressed
- link_ack  in  1  one-cycle pulse from the link block: connection established
- link_lost  in  1  one-cycle pulse from the link block: connection dropped
- mouse_on_start_button  out  1  pointer inside the Start region (registered)
- mouse_on_connect_button  out  1  pointer inside the Connect region (registered)
- start_pulse  out  1  one-cycle pulse: Start clicked
- connect_req  out  1  level: connection request outstanding
- connected  out  1  level: link up; drives the pixel generator's connect colour

Function
REQ-004 Hover outputs SHALL be registered from the current mouse_x/mouse_y using the inclusive region compare, with latency 1 cycle.
REQ-005 The hover flags SHALL never both be 1, because the regions do not overlap.
REQ-006 MOUSE_LEFT SHALL be registered into left_q. A press is detected when MOUSE_LEFT=1 and left_q=0; a release is detected when MOUSE_LEFT=0 and left_q=1.
REQ-007 The click FSM SHALL have the states C_IDLE, C_PRESS_START, C_PRESS_CONN and C_PRESS_NONE.
REQ-008 In C_IDLE, a press SHALL go to C_PRESS_START if the registered Start hover is 1, to C_PRESS_CONN if the registered Connect hover is 1, and to C_PRESS_NONE otherwise.
REQ-009 On a release in any C_PRESS_* state, the FSM SHALL return to C_IDLE.
REQ-010 On a release from C_PRESS_START with the registered Start hover still 1, start_pulse SHALL be 1 for exactly the next cycle.
REQ-011 On a release from C_PRESS_CONN with the registered Connect hover still 1, a connect_click event SHALL be raised internally, same timing as REQ-010.
REQ-012 A click SHALL be cancelled by dragging out of the button before release. Dragging into a button from C_PRESS_NONE SHALL never produce a click.
REQ-013 The link FSM SHALL have the states L_DISC, L_REQ and L_CONN. Outputs: connect_req = (state == L_REQ), connected = (state == L_CONN), both registered.
REQ-014 In L_DISC, connect_click SHALL go to L_REQ and clear the timeout counter.
REQ-015 In L_REQ, the counter SHALL increment each cycle. Transitions:
- link_ack SHALL go to L_CONN.
- When the counter reaches TIMEOUT-1 without an ack, the FSM SHALL go to L_DISC.
- link_ack in the same cycle as the timeout SHALL win (go to L_CONN).
REQ-016 In L_CONN, link_lost SHALL go to L_DISC, and connect_click SHALL be ignored.
REQ-017 link_lost in L_REQ SHALL go to L_DISC and SHALL take priority over a simultaneous link_ack.
REQ-018 connect_click in L_REQ SHALL be ignored: no counter restart.
REQ-019 link_ack in L_DISC SHALL be ignored.
REQ-020 start_pulse SHALL be independent of link state. It fires in any L_* state.

Reset
REQ-021 While rst=1 at a clk edge, the following SHALL be reset:
- All outputs SHALL be 0.
- left_q SHALL be 0.
- The click FSM SHALL be C_IDLE and the link FSM SHALL be L_DISC.
- The counter SHALL be 0.
REQ-022 Reset asserted mid-press or in L_REQ SHALL abandon the operation. There SHALL be no start_pulse and connect_req SHALL be 0 on the cycle after reset.
REQ-023 If MOUSE_LEFT is held high through reset deassertion, the first cycle after reset SHALL register a press, because left_q resets to 0.

Verification
REQ-024 Hover and boundaries: mouse (220,200) -> mouse_on_start_button=1 one cycle later. Mouse (219,200) -> 0. Mouse (419,419) -> mouse_on_connect_button=1. Mouse (420,419) -> 0.
REQ-025 Start click: mouse (300,250), MOUSE_LEFT 0->1, hold 5 cycles, then 1->0 -> start_pulse=1 for exactly 1 cycle, and connected stays 0.
REQ-026 Cancelled and drag-in clicks must not fire:
- Press at (300,250), move to (100,100), release -> no start_pulse.
- Press at (100,100), move to (300,250), release -> no start_pulse.
REQ-027 Connect handshake with TIMEOUT=16:
- Click at (300,350) -> connect_req=1.
- link_ack on the 5th cycle -> connected=1 and connect_req=0.
- A second connect click while connected -> no change.
- link_lost -> connected=0.
REQ-028 Timeout and priority with TIMEOUT=16:
- Click connect with no ack -> connect_req high for 16 cycles, then the FSM returns to L_DISC.
- Repeat with link_ack and link_lost together in L_REQ -> L_DISC.
REQ-029 Reset mid-operation: assert rst for 1 cycle during L_REQ with the button held -> all outputs 0. After release, one press is detected. connect_req stays 0 until a new connect click.
